// File: rtl/frame_hist_packer_pkg.sv
// rtl/frame_hist_packer_pkg.sv - shared sizes, packet constants and FSM encoding
package frame_hist_packer_pkg;

  localparam int DEF_DATA_SIZE   = 4;
  localparam int DEF_DATA_NUM    = 16;
  localparam int DEF_LENGTH      = 64;
  localparam int DEF_LENGTH_SIZE = 6;

  localparam logic [7:0] HEAD_BYTE0 = 8'hA5;
  localparam logic [7:0] HEAD_BYTE1 = 8'h5A;
  localparam int         PKT_LEN    = 51;
  localparam int         FRAME_BYTES = DEF_LENGTH / 2;

  // Byte index where each packet section begins
  localparam logic [5:0] IDX_FRAME0 = 6'd2;
  localparam logic [5:0] IDX_HIST0  = 6'(2 + FRAME_BYTES);
  localparam logic [5:0] IDX_CSUM   = 6'(PKT_LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CAPT  = 3'd1;
  localparam logic [2:0] S_HEAD  = 3'd2;
  localparam logic [2:0] S_FRAME = 3'd3;
  localparam logic [2:0] S_HIST  = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;

  function automatic logic [2:0] stateForIdx(input logic [5:0] idx);
    if (idx < IDX_FRAME0) return S_HEAD;
    if (idx < IDX_HIST0)  return S_FRAME;
    if (idx < IDX_CSUM)   return S_HIST;
    return S_CSUM;
  endfunction

endpackage

// File: rtl/tx_byte_reg.sv
// rtl/tx_byte_reg.sv - output byte register holding TxData/TxValid across the TxReady handshake
module tx_byte_reg (
  input  logic       clk,
  input  logic       rstn,
  input  logic       loadEn,
  input  logic [7:0] loadData,
  input  logic       clearEn,
  input  logic       TxReady,
  output logic [7:0] TxData,
  output logic       TxValid,
  output logic       xfer
);

  assign xfer = TxValid && TxReady;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      TxData  <= 8'h00;
      TxValid <= 1'b0;
    end else if (loadEn) begin
      TxData  <= loadData;
      TxValid <= 1'b1;
    end else if (clearEn) begin
      TxData  <= 8'h00;
      TxValid <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_hist_packer.sv
// rtl/frame_hist_packer.sv - captures a frame and histogram, then streams them as a 51-byte packet
module frame_hist_packer
  import frame_hist_packer_pkg::*;
#(
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int DATA_NUM    = DEF_DATA_NUM,
  parameter int LENGTH      = DEF_LENGTH,
  parameter int LENGTH_SIZE = DEF_LENGTH_SIZE
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   FramEn,
  input  logic [LENGTH_SIZE-1:0] FramAdd,
  input  logic [DATA_SIZE-1:0]   FramData,
  input  logic                   HistaEn,
  input  logic [DATA_SIZE-1:0]   HistaAdd,
  input  logic [LENGTH_SIZE-1:0] HistaData,
  output logic [7:0]             TxData,
  output logic                   TxValid,
  input  logic                   TxReady,
  output logic                   Busy,
  output logic                   Overrun
);

  logic [DATA_SIZE-1:0]   frameBuf [LENGTH];
  logic [LENGTH_SIZE-1:0] histBuf  [DATA_NUM];

  logic [2:0] state;
  logic [5:0] byteIdx;
  logic [5:0] loadIdx;
  logic [7:0] csum;
  logic [7:0] loadData;
  logic [4:0] frameOff;
  logic [3:0] histOff;
  logic       xfer;
  logic       lastXfer;
  logic       startPkt;
  logic       loadEn;
  logic       capWrite;

  assign Busy     = (state != S_IDLE) && (state != S_CAPT);
  assign capWrite = !Busy && (FramEn || HistaEn);
  assign startPkt = !Busy && FramEn && (FramAdd == LENGTH_SIZE'(LENGTH - 1));
  assign lastXfer = xfer && (byteIdx == IDX_CSUM);
  assign loadEn   = startPkt || (xfer && !lastXfer);

  // The byte being loaded is always the one after the byte on the wire
  assign loadIdx  = Busy ? byteIdx + 6'd1 : 6'd0;
  assign frameOff = 5'(loadIdx - IDX_FRAME0);
  assign histOff  = 4'(loadIdx - IDX_HIST0);

  always_comb begin
    loadData = csum;
    if (loadIdx == 6'd0)
      loadData = HEAD_BYTE0;
    else if (loadIdx == 6'd1)
      loadData = HEAD_BYTE1;
    else if (loadIdx < IDX_HIST0)
      loadData = 8'({frameBuf[{frameOff, 1'b1}], frameBuf[{frameOff, 1'b0}]});
    else if (loadIdx < IDX_CSUM)
      loadData = 8'(histBuf[histOff]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      byteIdx <= 6'd0;
      csum    <= 8'h00;
      Overrun <= 1'b0;
    end else begin
      if (Busy && (FramEn || HistaEn))
        Overrun <= 1'b1;
      if (startPkt) begin
        state   <= S_HEAD;
        byteIdx <= 6'd0;
        csum    <= 8'h00;
      end else if (lastXfer) begin
        state   <= S_IDLE;
        byteIdx <= 6'd0;
      end else if (xfer) begin
        byteIdx <= loadIdx;
        state   <= stateForIdx(loadIdx);
        // Sum each payload byte as it is loaded so the total is ready for the last slot
        if (loadIdx >= IDX_FRAME0 && loadIdx < IDX_CSUM)
          csum <= csum + loadData;
      end else if (capWrite) begin
        state <= S_CAPT;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LENGTH; i++)   frameBuf[i] <= '0;
      for (int i = 0; i < DATA_NUM; i++) histBuf[i]  <= '0;
    end else begin
      if (!Busy && FramEn)  frameBuf[FramAdd] <= FramData;
      if (!Busy && HistaEn) histBuf[HistaAdd] <= HistaData;
    end
  end

  tx_byte_reg uTxByte (
    .clk      (clk),
    .rstn     (rstn),
    .loadEn   (loadEn),
    .loadData (loadData),
    .clearEn  (lastXfer),
    .TxReady  (TxReady),
    .TxData   (TxData),
    .TxValid  (TxValid),
    .xfer     (xfer)
  );

endmodule

// File: tb/tb_frame_hist_packer.sv
// tb/tb_frame_hist_packer.sv - randomized self-checking bench for frame_hist_packer
module tb_frame_hist_packer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       FramEn = 1'b0;
  logic [5:0] FramAdd = '0;
  logic [3:0] FramData = '0;
  logic       HistaEn = 1'b0;
  logic [3:0] HistaAdd = '0;
  logic [5:0] HistaData = '0;
  logic [7:0] TxData;
  logic       TxValid;
  logic       TxReady = 1'b0;
  logic       Busy;
  logic       Overrun;

  always #5 clk = ~clk;

  frame_hist_packer dut (
    .clk       (clk),
    .rstn      (rstn),
    .FramEn    (FramEn),
    .FramAdd   (FramAdd),
    .FramData  (FramData),
    .HistaEn   (HistaEn),
    .HistaAdd  (HistaAdd),
    .HistaData (HistaData),
    .TxData    (TxData),
    .TxValid   (TxValid),
    .TxReady   (TxReady),
    .Busy      (Busy),
    .Overrun   (Overrun)
  );

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  int frameM [64];
  int histM  [16];
  bit ovrM;
  int nextFrame [64];
  int nextHist  [16];
  bit histWr    [16];
  int expPkt    [51];
  int obsCsum;

  function automatic void modelReset();
    foreach (frameM[i]) frameM[i] = 0;
    foreach (histM[i])  histM[i]  = 0;
    ovrM = 1'b0;
  endfunction

  function automatic void buildPacket();
    int sum = 0;
    expPkt[0] = 'hA5;
    expPkt[1] = 'h5A;
    for (int k = 0; k < 32; k++) begin
      expPkt[2 + k] = frameM[2 * k + 1] * 16 + frameM[2 * k];
      sum += expPkt[2 + k];
    end
    for (int b = 0; b < 16; b++) begin
      expPkt[34 + b] = histM[b];
      sum += histM[b];
    end
    expPkt[50] = sum % 256;
  endfunction

  function automatic void randomStim(input bit allBins);
    foreach (nextFrame[i]) nextFrame[i] = int'($urandom_range(0, 15));
    foreach (nextHist[i]) begin
      nextHist[i] = int'($urandom_range(0, 63));
      histWr[i]   = allBins ? 1'b1 : 1'($urandom_range(0, 1));
    end
  endfunction

  task automatic capture();
    for (int i = 0; i < 64; i++) begin
      FramEn    = 1'b1;
      FramAdd   = 6'(i);
      FramData  = 4'(nextFrame[i]);
      HistaEn   = (i < 16) && histWr[i % 16];
      HistaAdd  = 4'(i % 16);
      HistaData = 6'(nextHist[i % 16]);
      if (i == 32) chk("capt_busy", Busy, 0);
      @(posedge clk); #1;
      frameM[i] = nextFrame[i];
      if (i < 16 && histWr[i]) histM[i] = nextHist[i];
    end
    FramEn  = 1'b0;
    HistaEn = 1'b0;
  endtask

  // mode 0: TxReady=1, 1: random TxReady, 2: 5-cycle stall on byte 3
  task automatic recvPacket(input string tag, input int mode, input bit disturb, input int resetAt);
    int got = 0;
    int cyc = 0;
    int lastCyc = 0;
    int stall = 0;
    bit dropped = 1'b0;
    obsCsum = -1;
    buildPacket();
    chk({tag, ":valid_rise"}, TxValid, 1);
    while (got < 51 && cyc < 1000 && !dropped) begin
      case (mode)
        0:       TxReady = 1'b1;
        1:       TxReady = ($urandom_range(0, 3) != 0);
        default: TxReady = !(got == 3 && stall < 5);
      endcase
      FramEn   = disturb && (got == 10);
      FramAdd  = 6'd5;
      FramData = 4'h0;
      @(negedge clk);
      if (got == resetAt) begin
        rstn = 1'b0;
        #1;
        chk({tag, ":rst_valid"}, TxValid, 0);
        chk({tag, ":rst_busy"}, Busy, 0);
        chk({tag, ":rst_data"}, TxData, 0);
        modelReset();
        TxReady = 1'b0;
        FramEn  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        return;
      end
      if (!TxValid) begin
        chk({tag, ":valid_drop"}, TxValid, 1);
        dropped = 1'b1;
      end else if (TxReady) begin
        chk($sformatf("%s:byte%0d", tag, got), TxData, expPkt[got]);
        if (got == 50) obsCsum = int'(TxData);
        got++;
        lastCyc = cyc;
      end else begin
        chk($sformatf("%s:hold%0d", tag, got), TxData, expPkt[got]);
        stall++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    TxReady = 1'b0;
    FramEn  = 1'b0;
    if (disturb) ovrM = 1'b1;
    if (got < 51) chk({tag, ":timeout"}, got, 51);
    if (mode == 0) chk({tag, ":no_bubbles"}, lastCyc, 50);
    if (mode == 2) chk({tag, ":stall_cycles"}, stall, 5);
    chk({tag, ":busy_fall"}, Busy, 0);
    chk({tag, ":valid_fall"}, TxValid, 0);
    chk({tag, ":overrun"}, Overrun, ovrM);
  endtask

  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", TxValid, 0);
    chk("reset_data", TxData, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_overrun", Overrun, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    foreach (nextFrame[i]) nextFrame[i] = i % 16;
    foreach (nextHist[i]) begin nextHist[i] = 4; histWr[i] = 1'b1; end
    capture();
    recvPacket("ramp", 0, 1'b0, -1);
    chk("ramp_csum", obsCsum, 'h20);

    foreach (nextFrame[i]) nextFrame[i] = 15;
    foreach (nextHist[i]) begin nextHist[i] = 63; histWr[i] = 1'b1; end
    capture();
    recvPacket("full", 0, 1'b0, -1);
    chk("full_csum", obsCsum, 'hD0);

    randomStim(1'b1);
    capture();
    recvPacket("stall", 2, 1'b0, -1);

    randomStim(1'b1);
    capture();
    recvPacket("disturb", 0, 1'b1, -1);
    randomStim(1'b0);
    capture();
    recvPacket("after_ovr", 1, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      randomStim(1'b0);
      capture();
      recvPacket($sformatf("rand%0d", r), 1, 1'b0, -1);
    end

    randomStim(1'b1);
    capture();
    recvPacket("midrst", 0, 1'b0, 11);
    @(posedge clk); #1;
    chk("midrst_overrun", Overrun, 0);
    chk("midrst_idle_valid", TxValid, 0);
    randomStim(1'b0);
    capture();
    recvPacket("post_rst", 0, 1'b0, -1);

    foreach (nextFrame[i]) nextFrame[i] = 0;
    foreach (nextHist[i]) begin nextHist[i] = 0; histWr[i] = 1'b1; end
    capture();
    recvPacket("zero", 1, 1'b0, -1);
    chk("zero_csum", obsCsum, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/frame_hist_packer.md
FRAME_HIST_PACKER -- requirements
Module: frame_hist_packer

Interface
REQ-001 Parameters: DATA_SIZE=4 (frame sample width); DATA_NUM=16 (histogram bins); LENGTH=64 (samples per frame); LENGTH_SIZE=6 (frame address and bin-count width).
REQ-002 clk  in  1  single clock for the block; reset is asynchronous and active-low.
REQ-003 rstn  in  1  asynchronous active-low reset.
REQ-004 FramEn  in  1  frame sample write strobe.
REQ-005 FramAdd  in  LENGTH_SIZE  frame sample index.
REQ-006 FramData  in  DATA_SIZE  frame sample value.
REQ-007 HistaEn  in  1  histogram bin write strobe.
REQ-008 HistaAdd  in  DATA_SIZE  histogram bin index.
REQ-009 HistaData  in  LENGTH_SIZE  histogram bin count.
REQ-010 TxData  out  8  packet byte.
REQ-011 TxValid  out  1  TxData is valid.
REQ-012 TxReady  in  1  downstream accepts the byte; a transfer occurs when TxValid and TxReady are both high on a clk edge.
REQ-013 Busy  out  1  high while a packet is being sent.
REQ-014 Overrun  out  1  sticky flag: a write arrived while sending.

Function
REQ-015 Buffers: FrameBuf has LENGTH entries x DATA_SIZE; HistBuf has DATA_NUM entries x LENGTH_SIZE.
REQ-016 Buffer writes are accepted only in IDLE or CAPT: FramEn writes FramData to FrameBuf[FramAdd], and HistaEn writes HistaData to HistBuf[HistaAdd] in the same cycle.
REQ-017 FSM states are IDLE, CAPT, HEAD, FRAME, HIST, CSUM.
REQ-018 IDLE->CAPT on the first FramEn or HistaEn.
REQ-019 In IDLE or CAPT, FramEn with FramAdd==LENGTH-1 performs its write and moves the FSM to HEAD on the next edge.
REQ-020 Packet is 51 bytes: 0xA5, 0x5A, 32 frame bytes, 16 histogram bytes, 1 checksum byte.
REQ-021 Frame byte k (0..31) = {FrameBuf[2k+1], FrameBuf[2k]}, with the odd sample in the high nibble.
REQ-022 Histogram byte b (0..15) = {2'b00, HistBuf[b]}.
REQ-023 Checksum = sum mod 256 of the 48 frame and histogram bytes; the header is excluded.
REQ-024 TxValid rises the first cycle in HEAD and stays high until the checksum transfers; TxData is stable while TxValid=1 and TxReady=0.
REQ-025 Each transfer loads the next byte on the same edge; with TxReady held high the packet occupies 51 consecutive cycles with no bubbles.
REQ-026 After the checksum transfers: TxValid=0 and the FSM returns to IDLE; buffer contents are retained.
REQ-027 Busy=1 in HEAD, FRAME, HIST and CSUM; otherwise 0.
REQ-028 FramEn or HistaEn while Busy=1 is ignored (no buffer write) and sets Overrun=1 on the next edge; Overrun clears only on reset.
REQ-029 Checksum is accumulated in an 8-bit register that wraps and is cleared on entry to HEAD.
REQ-030 Histogram bins that are not written during capture are sent with their previous value.

Reset
REQ-031 rstn low asynchronously forces: FSM=IDLE, TxValid=0, TxData=0x00, Busy=0, Overrun=0, checksum=0, all buffer entries=0.
REQ-032 Reset during any state aborts the packet immediately; no partial byte is held after release.
REQ-033 After rstn rises, the block waits in IDLE for a new capture.

Structure
REQ-034 The shared package holds: the DATA_SIZE/DATA_NUM/LENGTH/LENGTH_SIZE defaults, the header constants 0xA5/0x5A, the packet length 51, and the FSM state encoding.
REQ-035 One sub-module, tx_byte_reg, holds TxData/TxValid with load/hold under the TxReady handshake; the FSM, buffers and checksum live in frame_hist_packer.

Verification
REQ-036 Frame sample i = i[3:0], all bins = 4, TxReady=1 -> 51 consecutive bytes: A5 5A, then (10 32 54 76 98 BA DC FE) x4, then 04 x16, then checksum 0x20; Busy then falls.
REQ-037 All samples 0xF, all bins 0x3F -> frame bytes FF x32, histogram bytes 3F x16, checksum 0xD0.
REQ-038 TxReady held low for 5 cycles while byte index 3 is presented -> TxData holds that byte and TxValid stays 1; the remaining sequence is unchanged.
REQ-039 FramEn pulsed during FRAME with FramData=0x0 -> Overrun=1, packet bytes identical to the undisturbed run, Overrun still 1 after the next capture.
REQ-040 rstn asserted while the 10th frame byte is presented -> TxValid=0 and Busy=0 immediately; a fresh capture then yields a complete, correct 51-byte packet.
REQ-041 All-zero capture -> frame and histogram bytes are 0x00 and the checksum is 0x00.
